// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file and its busy scoreboard.
// The same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_mp_pkg;

   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 5;
   localparam int NR_DEF   = 4;
   localparam int NW_DEF   = 2;
   localparam int REG_ZERO = 0;

   // Per-register busy update chosen each cycle, listed lowest to highest priority.
   typedef enum logic [1:0] {
      BUSY_HOLD  = 2'd0,
      BUSY_CLR   = 2'd1,
      BUSY_SET   = 2'd2,
      BUSY_FLUSH = 2'd3
   } busy_op_e;

endpackage : regfile_mp_pkg

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports, issue and flush.
// The master side is the pipeline; the slave side is regfile_mp.
interface regfile_mp_if #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 4,
   parameter int NW = 2
);

   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic [NW-1:0]    we;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic             iss_valid;
   logic [AW-1:0]    iss_addr;
   logic             flush;

   modport master (
      output raddr, we, waddr, wdata, iss_valid, iss_addr, flush,
      input  rdata, rbusy
   );

   modport slave (
      input  raddr, we, waddr, wdata, iss_valid, iss_addr, flush,
      output rdata, rbusy
   );

endinterface : regfile_mp_if

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, wiped by flush.
// Exposes the busy bit of every read port's register from registered state.
module regfile_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int NR = NR_DEF,
   parameter int NW = NW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NW-1:0]    we_i,
   input  logic [NW*AW-1:0] waddr_i,
   input  logic             iss_valid_i,
   input  logic [AW-1:0]    iss_addr_i,
   input  logic             flush_i,
   input  logic [NR*AW-1:0] raddr_i,
   output logic [NR-1:0]    rbusy_o
);

   localparam int DEPTH = 2**AW;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [DEPTH-1:0] clr_s;
   logic [DEPTH-1:0] set_s;
   busy_op_e         op_s [DEPTH];

   // Decode writeback clears and the issue set into one-hot register vectors.
   always_comb begin
      clr_s = '0;
      set_s = '0;
      for (int w = 0; w < NW; w++) begin
         if (we_i[w]) begin
            clr_s[waddr_i[w*AW +: AW]] = 1'b1;
         end else begin
            clr_s = clr_s;
         end
      end
      if (iss_valid_i && (iss_addr_i != '0)) begin
         set_s[iss_addr_i] = 1'b1;
      end else begin
         set_s = '0;
      end
   end

   // Priority per register: flush over a new producer over a writeback.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         if (flush_i) begin
            op_s[r] = BUSY_FLUSH;
         end else if (set_s[r]) begin
            op_s[r] = BUSY_SET;
         end else if (clr_s[r]) begin
            op_s[r] = BUSY_CLR;
         end else begin
            op_s[r] = BUSY_HOLD;
         end
      end
   end

   // Apply the selected operation; r0 can never be busy.
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < DEPTH; r++) begin
         case (op_s[r])
            BUSY_FLUSH: busy_d[r] = 1'b0;
            BUSY_SET:   busy_d[r] = 1'b1;
            BUSY_CLR:   busy_d[r] = 1'b0;
            BUSY_HOLD:  busy_d[r] = busy_q[r];
            default:    busy_d[r] = busy_q[r];
         endcase
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   // Busy vector state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Busy lookup for each read port.
   always_comb begin
      rbusy_o = '0;
      for (int p = 0; p < NR; p++) begin
         rbusy_o[p] = busy_q[raddr_i[p*AW +: AW]];
      end
   end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NR combinational read ports, NW write ports, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int NR = NR_DEF,
   parameter int NW = NW_DEF
) (
   input  logic         clk,
   input  logic         reset,
   regfile_mp_if.slave  bus
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DW-1:0]    mem_d [DEPTH];
   logic [NR-1:0]    sb_busy_s;
   logic [AW-1:0]    ra_s  [NR];
   logic [NR*DW-1:0] rdata_s;
   logic [NR-1:0]    rbusy_s;

   regfile_scoreboard #(
      .AW (AW),
      .NR (NR),
      .NW (NW)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .we_i        (bus.we),
      .waddr_i     (bus.waddr),
      .iss_valid_i (bus.iss_valid),
      .iss_addr_i  (bus.iss_addr),
      .flush_i     (bus.flush),
      .raddr_i     (bus.raddr),
      .rbusy_o     (sb_busy_s)
   );

   // Write arbitration: ports applied in index order so the highest index wins a collision.
   always_comb begin
      mem_d = mem_q;
      for (int w = 0; w < NW; w++) begin
         if (bus.we[w] && (bus.waddr[w*AW +: AW] != '0)) begin
            mem_d[bus.waddr[w*AW +: AW]] = bus.wdata[w*DW +: DW];
         end else begin
            mem_d = mem_d;
         end
      end
      mem_d[REG_ZERO] = '0;
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read ports, with optional forwarding from the writes committing this cycle.
   always_comb begin
      rdata_s = '0;
      rbusy_s = '0;
      for (int p = 0; p < NR; p++) begin
         ra_s[p] = bus.raddr[p*AW +: AW];
         if (ra_s[p] == '0) begin
            rdata_s[p*DW +: DW] = '0;
            rbusy_s[p]          = 1'b0;
         end else begin
            rdata_s[p*DW +: DW] = mem_q[ra_s[p]];
            rbusy_s[p]          = sb_busy_s[p];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NW; w++) begin
               if (bus.we[w] && (bus.waddr[w*AW +: AW] == ra_s[p])) begin
                  rdata_s[p*DW +: DW] = bus.wdata[w*DW +: DW];
                  rbusy_s[p]          = 1'b0;
               end else begin
                  rbusy_s[p] = rbusy_s[p];
               end
            end
`else
            rbusy_s[p] = rbusy_s[p];
`endif
         end
      end
   end

   assign bus.rdata = rdata_s;
   assign bus.rbusy = rbusy_s;

endmodule : regfile_mp
